// File: rtl/conv_relu_pool_stream.sv
// conv_relu_pool_stream
//   Takes one whole conv output frame (FILTERBATCH x OUTHEIGHT x OUTWIDTH
//   signed 2*BITWIDTH elements) per handshake. It then streams out one
//   2x2 / stride-2 max-pooled, ReLU'd, right-shifted and saturated
//   BITWIDTH value per cycle. Windows are walked column-first, then row,
//   then channel.
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   in_frame     packed frame, element (c,r,x) at [e*2*BITWIDTH +: 2*BITWIDTH],
//                e = (c*OUTHEIGHT + r)*OUTWIDTH + x
//   in_valid     frame present
//   in_ready     block can accept a frame (IDLE only)
//   out_data     pooled requantized value, 0 .. 2^(BITWIDTH-1)-1
//   out_channel  channel of out_data
//   out_valid    out_data valid
//   out_ready    consumer accepts
//   out_last     final pooled value of the frame
module conv_relu_pool_stream #(
  parameter int BITWIDTH    = 8,
  parameter int OUTWIDTH    = 4,
  parameter int OUTHEIGHT   = 4,
  parameter int FILTERBATCH = 2,
  parameter int SHIFT       = 2,
  localparam int CH_W       = (FILTERBATCH > 1) ? $clog2(FILTERBATCH) : 1,
  localparam int FW         = 2 * BITWIDTH * FILTERBATCH * OUTHEIGHT * OUTWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FW-1:0]       in_frame,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic [CH_W-1:0]     out_channel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int EW    = 2 * BITWIDTH;
  localparam int NE    = FILTERBATCH * OUTHEIGHT * OUTWIDTH;
  localparam int PW    = OUTWIDTH / 2;
  localparam int PH    = OUTHEIGHT / 2;
  localparam int PC_W  = (PW > 1) ? $clog2(PW) : 1;
  localparam int PR_W  = (PH > 1) ? $clog2(PH) : 1;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

  localparam logic [EW-1:0]   QMAX   = EW'((2 ** (BITWIDTH - 1)) - 1);
  localparam logic [CH_W-1:0] C_LAST = CH_W'(FILTERBATCH - 1);
  localparam logic [PR_W-1:0] R_LAST = PR_W'(PH - 1);
  localparam logic [PC_W-1:0] X_LAST = PC_W'(PW - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q;
  logic [CH_W-1:0] c_q, c_d;
  logic [PR_W-1:0] pr_q, pr_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic at_max;
  logic accept;

  assign at_max = (c_q == C_LAST) && (pr_q == R_LAST) && (pc_q == X_LAST);
  assign accept = (state_q == IDLE) && in_valid;

  // ---------------------------------------------------------------------
  // State, counters, frame store
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      pr_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      pr_q    <= pr_d;
      pc_q    <= pc_d;
    end
  end

  // Only written on accept, so a frame offered during RUN cannot disturb
  // the one being walked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (accept) begin
      frame_q <= in_frame;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    pr_d      = pr_q;
    pc_d      = pc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          c_d     = '0;
          pr_d    = '0;
          pc_d    = '0;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = at_max;
        if (out_ready) begin
          if (at_max) begin
            state_d = IDLE;
            c_d     = '0;
            pr_d    = '0;
            pc_d    = '0;
          end else if (pc_q != X_LAST) begin
            pc_d = pc_q + 1'b1;
          end else begin
            pc_d = '0;
            if (pr_q != R_LAST) begin
              pr_d = pr_q + 1'b1;
            end else begin
              pr_d = '0;
              c_d  = c_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Window datapath: pure function of the frame store and counters
  // ---------------------------------------------------------------------
  logic signed [EW-1:0] elem [NE];

  for (genvar gi = 0; gi < NE; gi++) begin : g_elem
    assign elem[gi] = frame_q[gi*EW +: EW];
  end

  logic [IDX_W-1:0]     idx00, idx01, idx10, idx11;
  logic signed [EW-1:0] w00, w01, w10, w11;
  logic signed [EW-1:0] m_top, m_bot, m_win;
  logic [EW-1:0]        relu_v, q_v;

  always_comb begin
    // Top-left element of the current window; the other three are offset
    // by one column and/or one row.
    idx00 = IDX_W'((int'(c_q) * OUTHEIGHT + 2 * int'(pr_q)) * OUTWIDTH + 2 * int'(pc_q));
    idx01 = IDX_W'(idx00 + 1);
    idx10 = IDX_W'(idx00 + OUTWIDTH);
    idx11 = IDX_W'(idx10 + 1);
    w00   = elem[idx00];
    w01   = elem[idx01];
    w10   = elem[idx10];
    w11   = elem[idx11];
    m_top = (w00 > w01) ? w00 : w01;
    m_bot = (w10 > w11) ? w10 : w11;
    m_win = (m_top > m_bot) ? m_top : m_bot;
    // After ReLU the value is non-negative, so a logical shift is exact.
    relu_v = m_win[EW-1] ? '0 : m_win;
    q_v    = relu_v >> SHIFT;
    out_data = (q_v > QMAX) ? QMAX[BITWIDTH-1:0] : q_v[BITWIDTH-1:0];
  end

  assign out_channel = c_q;

endmodule

// File: tb/tb_conv_relu_pool_stream.sv
// Directed bench for conv_relu_pool_stream at default parameters:
// table of whole-frame vectors with hand-computed pooled outputs, plus
// sequences for backpressure, back-to-back frames and mid-frame reset.
module tb_conv_relu_pool_stream;

  localparam int BW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int FB = 2;
  localparam int SH = 2;
  localparam int FW = 2 * BW * FB * H * W;
  localparam int NV = 8;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] in_frame;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic [0:0]    out_channel;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  conv_relu_pool_stream #(
    .BITWIDTH(BW), .OUTWIDTH(W), .OUTHEIGHT(H), .FILTERBATCH(FB), .SHIFT(SH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_frame   (in_frame),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_channel(out_channel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] frame;
    logic [63:0]   exp_data;   // value k in [k*8 +: 8]
    logic [7:0]    exp_chan;   // channel of value k in bit k
  } vec_t;

  vec_t vecs [4];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] ramp_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int e = 0; e < FW / 16; e++) f[e*16 +: 16] = 16'(e);
    return f;
  endfunction

  function automatic logic [FW-1:0] const_frame(input logic [15:0] v);
    logic [FW-1:0] f;
    f = '0;
    for (int e = 0; e < FW / 16; e++) f[e*16 +: 16] = v;
    return f;
  endfunction

  // One 0x0100 at each window's top-left, 0x8000 everywhere else.
  function automatic logic [FW-1:0] mix_frame();
    logic [FW-1:0] f;
    int e;
    f = '0;
    for (int c = 0; c < FB; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++) begin
          e = (c * H + r) * W + x;
          f[e*16 +: 16] = ((r % 2 == 0) && (x % 2 == 0)) ? 16'h0100 : 16'h8000;
        end
    return f;
  endfunction

  // Accept vecs[vi] with out_ready held high and check every emitted value.
  task automatic run_frame(input int vi, input string tag);
    chk($sformatf("%s_idle_in_ready", tag), 64'(in_ready), 64'd1);
    in_frame  = vecs[vi].frame;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_frame = '0;
    chk($sformatf("%s_first_valid", tag), 64'(out_valid), 64'd1);
    chk($sformatf("%s_busy_in_ready", tag), 64'(in_ready), 64'd0);
    for (int k = 0; k < NV; k++) begin
      chk($sformatf("%s_data[%0d]", tag, k), 64'(out_data), 64'(vecs[vi].exp_data[k*8 +: 8]));
      chk($sformatf("%s_chan[%0d]", tag, k), 64'(out_channel), 64'(vecs[vi].exp_chan[k]));
      chk($sformatf("%s_last[%0d]", tag, k), 64'(out_last), 64'(k == NV - 1));
      $display("%s: value %0d data=%0d chan=%0d last=%0b", tag, k, out_data, out_channel, out_last);
      tick();
    end
    chk($sformatf("%s_ready_after", tag), 64'(in_ready), 64'd1);
    chk($sformatf("%s_valid_after", tag), 64'(out_valid), 64'd0);
  endtask

  logic [63:0] ramp_exp;
  int          k;
  int          cyc;
  logic        rdy;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ramp_exp = 64'h0707_0505_0303_0101;

    vecs[0].frame = ramp_frame();            vecs[0].exp_data = ramp_exp;
    vecs[1].frame = const_frame(16'hFF00);   vecs[1].exp_data = 64'h0;
    vecs[2].frame = const_frame(16'h7FFF);   vecs[2].exp_data = 64'h7F7F_7F7F_7F7F_7F7F;
    vecs[3].frame = mix_frame();             vecs[3].exp_data = 64'h4040_4040_4040_4040;
    for (int i = 0; i < 4; i++) vecs[i].exp_chan = 8'b1111_0000;

    // ---- reset with random inputs ----
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < FW / 32; i++) in_frame[i*32 +: 32] = $urandom();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_channel", 64'(out_channel), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_frame  = '0;
    rst_n     = 1'b1;
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
    end

    // ---- table-driven frames ----
    for (int vi = 0; vi < 4; vi++) run_frame(vi, $sformatf("vec%0d", vi));

    // ---- backpressure, second frame held on in_valid throughout ----
    in_frame  = vecs[0].frame;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_frame = vecs[2].frame;
    k   = 0;
    cyc = 0;
    while (k < NV && cyc < 200) begin
      chk($sformatf("bp_valid[%0d]", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_in_ready[%0d]", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp_data[%0d]", k), 64'(out_data), 64'(ramp_exp[k*8 +: 8]));
      chk($sformatf("bp_chan[%0d]", k), 64'(out_channel), 64'(k >= 4));
      chk($sformatf("bp_last[%0d]", k), 64'(out_last), 64'(k == NV - 1));
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      $display("bp: cycle %0d value %0d data=%0d ready=%0b", cyc, k, out_data, rdy);
      tick();
      if (rdy) k++;
      cyc++;
    end
    chk("bp_transfers", 64'(k), 64'(NV));
    // Bubble cycle: second frame still offered but not yet taken.
    chk("bp_bubble_in_ready", 64'(in_ready), 64'd1);
    chk("bp_bubble_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_data", 64'(out_data), 64'd127);
    cyc = 0;
    while (!(out_valid && out_last) && cyc < 20) begin
      chk($sformatf("bp2_data[%0d]", cyc), 64'(out_data), 64'd127);
      tick();
      cyc++;
    end
    chk("bp2_count", 64'(cyc), 64'(NV - 1));
    tick();
    chk("bp2_idle", 64'(in_ready), 64'd1);

    // ---- reset in the middle of a frame ----
    in_frame  = vecs[0].frame;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int r = 0; r < 3; r++) tick();
    chk("mid_before_data", 64'(out_data), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    $display("mid-frame reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
